// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, redirect and memory-wait control for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  input  logic [4:0]       Rt_ID_EX,
  input  logic             MemRead_ID_EX,
  input  logic             BranchTaken_EX,
  input  logic             J_ID_EX,
  input  logic             JR_ID_EX,
  input  logic             JAL_ID_EX,
  input  logic             MemAccess_EX_MEM,
  output logic             Enable_PC,
  output logic             Enable_IF_ID,
  output logic             Enable_ID_EX,
  output logic             Enable_EX_MEM,
  output logic             Enable_MEM_WB,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             PCRedirect,
  output logic             MemBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Wait cycles after the entry cycle; only meaningful when the memory is multi-cycle.
  localparam logic [3:0]       CNT_LOAD = 4'(MEM_LAT - 2);
  localparam logic             MULTI    = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       freeze;
  logic       redirect;
  logic       loaduse;

  // Hazard detection and stage control; freeze outranks redirect, redirect outranks load-use.
  always_comb begin
    freeze   = ((state == ST_RUN) && MemAccess_EX_MEM && MULTI) ||
               ((state == ST_MEM_WAIT) && (cnt != 4'd0));
    redirect = BranchTaken_EX | J_ID_EX | JR_ID_EX | JAL_ID_EX;
    loaduse  = MemRead_ID_EX && (Rt_ID_EX != 5'd0) &&
               ((Rt_ID_EX == Rs_IF_ID) || (Rt_ID_EX == Rt_IF_ID));

    Enable_PC     = 1'b0;
    Enable_IF_ID  = 1'b0;
    Enable_ID_EX  = 1'b0;
    Enable_EX_MEM = 1'b0;
    Enable_MEM_WB = 1'b0;
    Flush_IF_ID   = 1'b0;
    Flush_ID_EX   = 1'b0;
    PCRedirect    = 1'b0;
    MemBusy       = 1'b0;

    if (reset) begin
      // everything held low
    end else if (freeze) begin
      MemBusy = 1'b1;
    end else if (redirect) begin
      // the dependent instruction of any load-use is flushed here anyway
      Enable_PC     = 1'b1;
      Enable_IF_ID  = 1'b1;
      Enable_ID_EX  = 1'b1;
      Enable_EX_MEM = 1'b1;
      Enable_MEM_WB = 1'b1;
      Flush_IF_ID   = 1'b1;
      Flush_ID_EX   = 1'b1;
      PCRedirect    = 1'b1;
    end else if (loaduse) begin
      Enable_ID_EX  = 1'b1;
      Enable_EX_MEM = 1'b1;
      Enable_MEM_WB = 1'b1;
      Flush_ID_EX   = 1'b1;
    end else begin
      Enable_PC     = 1'b1;
      Enable_IF_ID  = 1'b1;
      Enable_ID_EX  = 1'b1;
      Enable_EX_MEM = 1'b1;
      Enable_MEM_WB = 1'b1;
    end
  end

  // Memory wait sequencing: entry cycle in RUN, MEM_LAT-2 counted cycles, then one release cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (MemAccess_EX_MEM && MULTI) begin
          state_nxt = ST_MEM_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ST_MEM_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State registers and the saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      cnt        <= 4'd0;
      StallCount <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!Enable_PC && (StallCount != CNT_MAX)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Covers three cases:
  - Load-use stalls: insert a bubble in ID_EX.
  - Control redirects from branch/J/JR/JAL: flush the younger stages.
  - Multi-cycle data-memory accesses: freeze the whole pipeline via a wait FSM.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MEM_LAT, 3, data-memory access latency in cycles. Legal range 1..16; 1 means no memory stall.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Rs_IF_ID  input  5  Rs field of the instruction in ID
- Rt_IF_ID  input  5  Rt field of the instruction in ID
- Rt_ID_EX  input  5  Rt of the instruction in EX
- MemRead_ID_EX  input  1  the EX instruction is a load
- BranchTaken_EX  input  1  BEQ/BNE resolved taken in EX
- J_ID_EX  input  1  J in EX
- JR_ID_EX  input  1  JR in EX
- JAL_ID_EX  input  1  JAL in EX
- MemAccess_EX_MEM  input  1  the MEM-stage instruction reads or writes data memory
- Enable_PC  output  1  PC load enable
- Enable_IF_ID  output  1  IF_ID load enable
- Enable_ID_EX  output  1  ID_EX load enable
- Enable_EX_MEM  output  1  EX_MEM load enable
- Enable_MEM_WB  output  1  MEM_WB load enable
- Flush_IF_ID  output  1  load a NOP into IF_ID at the next edge
- Flush_ID_EX  output  1  zero all ID_EX control bits at the next edge (bubble)
- PCRedirect  output  1  PC mux selects the EX-computed target
- MemBusy  output  1  pipeline is frozen for memory
- StallCount  output  CNT_W  cycles with Enable_PC=0 since reset

Behaviour:
- The FSM has two states: RUN and MEM_WAIT. It contains a wait counter cnt (4 bits).
- Reset: when reset=1 at a rising edge, set state=RUN, cnt=0, StallCount=0.
- While reset=1, outputs are forced combinationally:
  - all Enable_*=0;
  - Flush_*=0, PCRedirect=0, MemBusy=0.
- All other outputs are combinational from state, cnt and the current inputs. Hazard response therefore takes effect at the same-cycle edge, with zero latency.
- freeze is asserted in either of these cases:
  - state=RUN and MemAccess_EX_MEM=1 and MEM_LAT>1;
  - state=MEM_WAIT and cnt!=0.
- While freeze=1:
  - all five enables are 0;
  - Flush_IF_ID=0, Flush_ID_EX=0, PCRedirect=0;
  - MemBusy=1.
  - Redirects and load-use hazards are not acted on; they are re-evaluated on the release cycle.
- FSM transitions:
  - RUN to MEM_WAIT: when MemAccess_EX_MEM=1 and MEM_LAT>1. Load cnt=MEM_LAT-2.
  - MEM_WAIT with cnt!=0: decrement cnt, stay in MEM_WAIT.
  - MEM_WAIT with cnt==0: release cycle. Freeze is not asserted, normal hazard logic applies, next state is RUN.
  - Total frozen cycles per memory access = MEM_LAT-1.
- Back-to-back memory instructions: after release the next MEM-stage access re-enters MEM_WAIT from RUN. No idle gap is required.
- Normal operation (no freeze):
  - redirect = BranchTaken_EX | J_ID_EX | JR_ID_EX | JAL_ID_EX.
  - loaduse = MemRead_ID_EX & (Rt_ID_EX!=0) & ((Rt_ID_EX==Rs_IF_ID) | (Rt_ID_EX==Rt_IF_ID)).
- If redirect=1:
  - PCRedirect=1, Flush_IF_ID=1, Flush_ID_EX=1;
  - all enables 1;
  - loaduse is ignored, because the dependent instruction is being flushed.
- Else if loaduse=1:
  - Enable_PC=0, Enable_IF_ID=0;
  - Flush_ID_EX=1, Enable_ID_EX=1;
  - Enable_EX_MEM=1, Enable_MEM_WB=1.
  - Exactly one bubble is inserted: the next cycle the load is in MEM, so loaduse deasserts.
- Otherwise: all enables 1, all flushes 0, PCRedirect=0.
- StallCount:
  - increments at every non-reset edge where Enable_PC=0;
  - saturates at 2^CNT_W-1 (no wrap).
- Reset mid-MEM_WAIT: the FSM returns to RUN at that edge and no residual freeze remains.

Test Plan:
- Load-use: Rt_ID_EX=8, MemRead_ID_EX=1, Rs_IF_ID=8, MEM_LAT=1.
  - Expect Enable_PC=0, Enable_IF_ID=0, Flush_ID_EX=1 for exactly 1 cycle, and StallCount=1.
  - Repeat with Rt_ID_EX=0: expect no stall.
- Redirect priority: BranchTaken_EX=1 and loaduse conditions true in the same cycle.
  - Expect PCRedirect=1, Flush_IF_ID=1, Flush_ID_EX=1, all enables 1, StallCount unchanged.
- Memory wait: MEM_LAT=3, MemAccess_EX_MEM=1 in RUN.
  - Expect MemBusy=1 and all enables 0 for exactly 2 cycles, then release.
  - Expect StallCount +2.
  - With MEM_LAT=1: never frozen.
- Redirect during freeze: MEM_LAT=4, J_ID_EX=1 held across the freeze.
  - Expect PCRedirect=0 for the 3 frozen cycles, then PCRedirect=1 on the release cycle.
- Reset mid-wait: MEM_LAT=8, assert reset during the 3rd frozen cycle.
  - Expect outputs forced low while reset=1, then state RUN and StallCount=0.
  - Expect no freeze unless MemAccess_EX_MEM=1.
- Saturation: CNT_W=4 with a continuous memory stall (MEM_LAT=16, back-to-back accesses).
  - Expect StallCount stops at 15.
